// File: rtl/obi_uart_rx_pkg.sv
// Shared types and helpers for the UART receiver: FSM states, FIFO entry layout,
// parity and trigger-level decoding.
package obi_uart_rx_pkg;

    localparam int unsigned EntryWidth = 11;

    typedef enum logic [2:0] {
        RXIDLE,
        RXSTART,
        RXDATA,
        RXPAR,
        RXSTOP
    } state_type_rx;

    typedef struct packed {
        logic       be;
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_fifo_entry_t;

    function automatic logic exp_parity(input logic [7:0] data, input logic [1:0] sel);
        case (sel)
            2'b00:   return ~^data;
            2'b01:   return ^data;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] trig_level(input logic [1:0] sel);
        case (sel)
            2'b00:   return 5'd1;
            2'b01:   return 5'd4;
            2'b10:   return 5'd8;
            default: return 5'd14;
        endcase
    endfunction

endpackage

// File: rtl/obi_uart_rx_fifo.sv
// Power-of-two FIFO with synchronous flush; a push into a full FIFO succeeds
// when a pop happens in the same cycle.
module obi_uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   usage_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = AddrW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AddrW-1:0]      r_rd_ptr;
    logic [AddrW-1:0]      r_wr_ptr;
    logic [CntW-1:0]       r_count;
    logic                  w_push;
    logic                  w_pop;

    assign full_o  = (r_count == CntW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign usage_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AddrW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AddrW'(1);
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/obi_uart_rx.sv
// UART receiver: 16x oversampled framing, per-character error status, FIFO or
// single holding register, sticky LSR flags, trigger and character timeout.
module obi_uart_rx
    import obi_uart_rx_pkg::*;
#(
    parameter int unsigned FifoDepth     = 16,
    parameter int unsigned TimeoutCycles = 640
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sample_edge_i,
    input  logic       rxd_i,
    input  logic [1:0] word_len_i,
    input  logic       par_en_i,
    input  logic [1:0] par_sel_i,
    input  logic       fifo_en_i,
    input  logic       fifo_rst_i,
    input  logic [1:0] rx_trig_i,
    input  logic       rbr_read_i,
    input  logic       lsr_read_i,
    output logic [7:0] rbr_data_o,
    output logic       data_ready_o,
    output logic       overrun_o,
    output logic       parity_err_o,
    output logic       framing_err_o,
    output logic       break_o,
    output logic       fifo_err_o,
    output logic       trigger_o,
    output logic       timeout_o,
    output logic       fifo_rst_ack_o
);

    localparam int unsigned UsageW = $clog2(FifoDepth) + 1;
    localparam int unsigned ToW    = $clog2(TimeoutCycles + 1);

    logic [1:0]      r_sync;
    state_type_rx    r_state;
    logic [3:0]      r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_pe;
    logic            r_zero;
    logic            r_armed;
    logic            r_push;
    rx_fifo_entry_t  r_entry;
    rx_fifo_entry_t  r_hold;
    logic            r_hold_valid;
    logic            r_new_head;
    logic [7:0]      r_rbr_data;
    logic            r_data_ready;
    logic            r_overrun, r_pe_flag, r_fe_flag, r_be_flag;
    logic [UsageW-1:0] r_err_cnt;
    logic            r_fifo_err;
    logic            r_trigger;
    logic [ToW-1:0]  r_to_cnt;
    logic            r_timeout;
    logic            r_rst_ack;

    logic                  w_rxs;
    logic [2:0]            w_last_idx;
    logic                  w_flush, w_fifo_push, w_fifo_pop;
    logic                  w_fifo_full, w_fifo_empty;
    logic [UsageW-1:0]     w_usage;
    logic [EntryWidth-1:0] w_fifo_rdata;
    rx_fifo_entry_t        w_fifo_head, w_head;
    logic                  w_pop_ok, w_push_ok, w_q_empty, w_new_head, w_overrun_set;
    logic                  w_err_push, w_err_pop;
    logic [UsageW-1:0]     w_err_cnt_nxt;

    assign w_rxs      = r_sync[1];
    assign w_last_idx = 3'd4 + 3'(word_len_i);

    // Frame FSM; after a break the line must return to mark before a new start is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync    <= 2'b11;
            r_state   <= RXIDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_pe      <= 1'b0;
            r_zero    <= 1'b0;
            r_armed   <= 1'b1;
            r_push    <= 1'b0;
            r_entry   <= '0;
        end else begin
            r_sync <= {r_sync[0], rxd_i};
            r_push <= 1'b0;
            if (sample_edge_i) begin
                case (r_state)
                    RXIDLE: begin
                        if (w_rxs) begin
                            r_armed <= 1'b1;
                        end else if (r_armed) begin
                            r_state <= RXSTART;
                            r_cnt   <= '0;
                        end
                    end
                    RXSTART: begin
                        if (r_cnt == 4'd7) begin
                            r_cnt <= '0;
                            if (!w_rxs) begin
                                r_state   <= RXDATA;
                                r_bit_idx <= '0;
                                r_shift   <= '0;
                                r_pe      <= 1'b0;
                                r_zero    <= 1'b1;
                            end else begin
                                r_state <= RXIDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    RXDATA: begin
                        if (r_cnt == 4'd15) begin
                            r_cnt <= '0;
                            r_shift[r_bit_idx] <= w_rxs;
                            if (w_rxs) r_zero <= 1'b0;
                            if (r_bit_idx == w_last_idx) r_state <= par_en_i ? RXPAR : RXSTOP;
                            else                         r_bit_idx <= r_bit_idx + 3'd1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    RXPAR: begin
                        if (r_cnt == 4'd15) begin
                            r_cnt   <= '0;
                            r_state <= RXSTOP;
                            if (w_rxs != exp_parity(r_shift, par_sel_i)) r_pe <= 1'b1;
                            if (w_rxs) r_zero <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    RXSTOP: begin
                        if (r_cnt == 4'd15) begin
                            r_cnt      <= '0;
                            r_state    <= RXIDLE;
                            r_push     <= 1'b1;
                            r_entry.be <= r_zero && !w_rxs;
                            r_entry.fe <= !w_rxs;
                            r_entry.pe <= r_pe;
                            r_entry.data <= r_shift;
                            if (r_zero && !w_rxs) r_armed <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    default: r_state <= RXIDLE;
                endcase
            end
        end
    end

    assign w_flush     = rst_i | fifo_rst_i | ~fifo_en_i;
    assign w_fifo_push = r_push && fifo_en_i;
    assign w_fifo_pop  = rbr_read_i && fifo_en_i;

    obi_uart_rx_fifo #(
        .DATA_WIDTH (EntryWidth),
        .DEPTH      (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (1'b1),
        .flush_i (w_flush),
        .push_i  (w_fifo_push),
        .pop_i   (w_fifo_pop),
        .data_i  (r_entry),
        .data_o  (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .usage_o (w_usage)
    );

    assign w_fifo_head = rx_fifo_entry_t'(w_fifo_rdata);
    assign w_pop_ok    = w_fifo_pop && !w_fifo_empty && !w_flush;
    assign w_push_ok   = w_fifo_push && (!w_fifo_full || w_pop_ok) && !w_flush;
    assign w_head      = fifo_en_i ? w_fifo_head : r_hold;
    assign w_q_empty   = fifo_en_i ? w_fifo_empty : !r_hold_valid;

    // A new character reaches the head either by landing in an empty queue or by a pop exposing the next one.
    assign w_new_head = fifo_en_i ? ((w_push_ok && w_fifo_empty) ||
                                     (w_pop_ok && (w_usage > UsageW'(1) || w_push_ok)))
                                  : r_push;
    assign w_overrun_set = fifo_en_i ? (r_push && w_fifo_full && !w_pop_ok && !w_flush)
                                     : (r_push && r_hold_valid && !rbr_read_i);

    assign w_err_push    = w_push_ok && (r_entry.be || r_entry.fe || r_entry.pe);
    assign w_err_pop     = w_pop_ok && (w_fifo_head.be || w_fifo_head.fe || w_fifo_head.pe);
    assign w_err_cnt_nxt = w_flush ? '0 : r_err_cnt + UsageW'(w_err_push) - UsageW'(w_err_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_new_head   <= 1'b0;
            r_rbr_data   <= '0;
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
            r_pe_flag    <= 1'b0;
            r_fe_flag    <= 1'b0;
            r_be_flag    <= 1'b0;
            r_err_cnt    <= '0;
            r_fifo_err   <= 1'b0;
            r_trigger    <= 1'b0;
            r_to_cnt     <= '0;
            r_timeout    <= 1'b0;
            r_rst_ack    <= 1'b0;
        end else begin
            if (fifo_en_i) begin
                r_hold_valid <= 1'b0;
            end else if (r_push) begin
                r_hold       <= r_entry;
                r_hold_valid <= 1'b1;
            end else if (rbr_read_i) begin
                r_hold_valid <= 1'b0;
            end
            r_new_head   <= w_new_head;
            r_data_ready <= !w_q_empty;
            if (!w_q_empty) r_rbr_data <= w_head.data;
            r_overrun <= w_overrun_set | (r_overrun & ~lsr_read_i);
            r_pe_flag <= (r_new_head && !w_q_empty && w_head.pe) | (r_pe_flag & ~lsr_read_i);
            r_fe_flag <= (r_new_head && !w_q_empty && w_head.fe) | (r_fe_flag & ~lsr_read_i);
            r_be_flag <= (r_new_head && !w_q_empty && w_head.be) | (r_be_flag & ~lsr_read_i);
            r_err_cnt  <= w_err_cnt_nxt;
            r_fifo_err <= (w_err_cnt_nxt != '0);
            r_trigger  <= fifo_en_i && (w_usage >= UsageW'(trig_level(rx_trig_i)));
            r_rst_ack  <= fifo_rst_i && fifo_en_i;
            if (w_push_ok || w_pop_ok || w_fifo_empty || w_flush) begin
                r_to_cnt  <= '0;
                r_timeout <= 1'b0;
            end else if (sample_edge_i && !r_timeout) begin
                r_to_cnt <= r_to_cnt + ToW'(1);
                if (r_to_cnt == ToW'(TimeoutCycles - 1)) r_timeout <= 1'b1;
            end
        end
    end

    assign rbr_data_o     = r_rbr_data;
    assign data_ready_o   = r_data_ready;
    assign overrun_o      = r_overrun;
    assign parity_err_o   = r_pe_flag;
    assign framing_err_o  = r_fe_flag;
    assign break_o        = r_be_flag;
    assign fifo_err_o     = r_fifo_err;
    assign trigger_o      = r_trigger;
    assign timeout_o      = r_timeout;
    assign fifo_rst_ack_o = r_rst_ack;

endmodule

// File: tb/tb_obi_uart_rx.sv
// Directed bench for obi_uart_rx: table of single-character frames plus
// hand-written glitch, break, overrun, flush, timeout, holding-register and reset sequences.
module tb_obi_uart_rx;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       sample_edge_i = 1'b0;
    logic       rxd_i = 1'b1;
    logic [1:0] word_len_i = 2'b11;
    logic       par_en_i = 1'b0;
    logic [1:0] par_sel_i = 2'b00;
    logic       fifo_en_i = 1'b1;
    logic       fifo_rst_i = 1'b0;
    logic [1:0] rx_trig_i = 2'b00;
    logic       rbr_read_i = 1'b0;
    logic       lsr_read_i = 1'b0;
    logic [7:0] rbr_data_o;
    logic       data_ready_o, overrun_o, parity_err_o, framing_err_o, break_o;
    logic       fifo_err_o, trigger_o, timeout_o, fifo_rst_ack_o;

    obi_uart_rx dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sample_edge_i  (sample_edge_i),
        .rxd_i          (rxd_i),
        .word_len_i     (word_len_i),
        .par_en_i       (par_en_i),
        .par_sel_i      (par_sel_i),
        .fifo_en_i      (fifo_en_i),
        .fifo_rst_i     (fifo_rst_i),
        .rx_trig_i      (rx_trig_i),
        .rbr_read_i     (rbr_read_i),
        .lsr_read_i     (lsr_read_i),
        .rbr_data_o     (rbr_data_o),
        .data_ready_o   (data_ready_o),
        .overrun_o      (overrun_o),
        .parity_err_o   (parity_err_o),
        .framing_err_o  (framing_err_o),
        .break_o        (break_o),
        .fifo_err_o     (fifo_err_o),
        .trigger_o      (trigger_o),
        .timeout_o      (timeout_o),
        .fifo_rst_ack_o (fifo_rst_ack_o)
    );

    always #5 clk_i = ~clk_i;

    // 16x sample pulse every fourth clock, changed on the falling edge
    int unsigned div = 0;
    always @(negedge clk_i) begin
        sample_edge_i = (div == 3);
        div = (div + 1) % 4;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%02h expected=0x%02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n * 4) @(negedge clk_i);
    endtask

    task automatic send_bit(input logic b);
        rxd_i = b;
        wait_edges(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen, input logic pb);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (pen) send_bit(pb);
        send_bit(1'b1);
        wait_edges(4);
    endtask

    task automatic pulse_read();
        rbr_read_i = 1'b1;
        @(negedge clk_i);
        rbr_read_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic pulse_lsr();
        lsr_read_i = 1'b1;
        @(negedge clk_i);
        lsr_read_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic check_all_zero(input string tag);
        chk8({tag, "_rbr"}, rbr_data_o, 8'h00);
        chk1({tag, "_ready"}, data_ready_o, 1'b0);
        chk1({tag, "_oe"}, overrun_o, 1'b0);
        chk1({tag, "_pe"}, parity_err_o, 1'b0);
        chk1({tag, "_fe"}, framing_err_o, 1'b0);
        chk1({tag, "_bi"}, break_o, 1'b0);
        chk1({tag, "_ferr"}, fifo_err_o, 1'b0);
        chk1({tag, "_trig"}, trigger_o, 1'b0);
        chk1({tag, "_tmo"}, timeout_o, 1'b0);
        chk1({tag, "_ack"}, fifo_rst_ack_o, 1'b0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] wl;
        logic       pen;
        logic [1:0] psel;
        logic       pb;
        logic [7:0] exp_data;
        logic       exp_pe;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'hA5, 2'b11, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b0};  // 8N1
        vecs[1] = '{8'h35, 2'b10, 1'b1, 2'b01, 1'b1, 8'h35, 1'b1};  // 7E1, bad parity
        vecs[2] = '{8'h35, 2'b10, 1'b1, 2'b01, 1'b0, 8'h35, 1'b0};  // 7E1, good parity
        vecs[3] = '{8'h1F, 2'b00, 1'b1, 2'b00, 1'b0, 8'h1F, 1'b0};  // 5O1, good
        vecs[4] = '{8'hFF, 2'b01, 1'b0, 2'b00, 1'b0, 8'h3F, 1'b0};  // 6N1, zero-extended
        vecs[5] = '{8'h5A, 2'b11, 1'b1, 2'b10, 1'b0, 8'h5A, 1'b1};  // forced 1, sent 0
        vecs[6] = '{8'h5A, 2'b11, 1'b1, 2'b11, 1'b0, 8'h5A, 1'b0};  // forced 0, sent 0
        vecs[7] = '{8'h2C, 2'b10, 1'b1, 2'b00, 1'b1, 8'h2C, 1'b1};  // 7O1, bad parity

        repeat (4) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;
        wait_edges(4);

        for (int i = 0; i < 8; i++) begin
            word_len_i = vecs[i].wl;
            par_en_i   = vecs[i].pen;
            par_sel_i  = vecs[i].psel;
            send_bit(1'b0);
            for (int b = 0; b < int'(vecs[i].wl) + 5; b++) send_bit(vecs[i].data[b]);
            if (vecs[i].pen) send_bit(vecs[i].pb);
            chk1("vec_ready_before_stop", data_ready_o, 1'b0);
            send_bit(1'b1);
            wait_edges(4);
            chk8("vec_data", rbr_data_o, vecs[i].exp_data);
            chk1("vec_ready", data_ready_o, 1'b1);
            chk1("vec_pe", parity_err_o, vecs[i].exp_pe);
            chk1("vec_fe", framing_err_o, 1'b0);
            chk1("vec_fifo_err", fifo_err_o, vecs[i].exp_pe);
            pulse_read();
            pulse_lsr();
            chk1("vec_ready_after_read", data_ready_o, 1'b0);
            chk1("vec_pe_after_lsr", parity_err_o, 1'b0);
            chk1("vec_fifo_err_after_read", fifo_err_o, 1'b0);
        end

        word_len_i = 2'b11;
        par_en_i   = 1'b0;

        // Short low pulse is rejected; the next real frame still arrives intact
        rxd_i = 1'b0;
        wait_edges(5);
        rxd_i = 1'b1;
        wait_edges(30);
        chk1("glitch_ready", data_ready_o, 1'b0);
        send_frame(8'h3C, 8, 1'b0, 1'b0);
        chk8("after_glitch_data", rbr_data_o, 8'h3C);
        chk1("after_glitch_ready", data_ready_o, 1'b1);
        pulse_read();

        // Line held low for two frame times yields a single break character
        rxd_i = 1'b0;
        wait_edges(320);
        rxd_i = 1'b1;
        wait_edges(40);
        chk1("break_ready", data_ready_o, 1'b1);
        chk8("break_data", rbr_data_o, 8'h00);
        chk1("break_bi", break_o, 1'b1);
        chk1("break_fe", framing_err_o, 1'b1);
        chk1("break_pe", parity_err_o, 1'b0);
        chk1("break_fifo_err", fifo_err_o, 1'b1);
        pulse_read();
        chk1("break_single_entry", data_ready_o, 1'b0);
        chk1("break_fifo_err_clr", fifo_err_o, 1'b0);
        chk1("break_bi_sticky", break_o, 1'b1);
        pulse_lsr();
        chk1("break_bi_clr", break_o, 1'b0);
        chk1("break_fe_clr", framing_err_o, 1'b0);

        // Seventeen characters into a sixteen-entry FIFO
        rx_trig_i = 2'b11;
        for (int i = 0; i < 17; i++) send_frame(8'(i), 8, 1'b0, 1'b0);
        chk1("ovr_overrun", overrun_o, 1'b1);
        chk1("ovr_trigger", trigger_o, 1'b1);
        chk1("ovr_ready", data_ready_o, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk8("ovr_drain", rbr_data_o, 8'(i));
            pulse_read();
        end
        chk1("ovr_empty", data_ready_o, 1'b0);
        chk8("ovr_hold_last", rbr_data_o, 8'h0F);
        chk1("ovr_trigger_low", trigger_o, 1'b0);
        pulse_lsr();
        chk1("ovr_overrun_clr", overrun_o, 1'b0);
        rx_trig_i = 2'b00;

        // FIFO reset request flushes a held character
        send_frame(8'h66, 8, 1'b0, 1'b0);
        chk1("frst_ready_before", data_ready_o, 1'b1);
        fifo_rst_i = 1'b1;
        @(negedge clk_i);
        fifo_rst_i = 1'b0;
        chk1("frst_ack", fifo_rst_ack_o, 1'b1);
        @(negedge clk_i);
        chk1("frst_ack_pulse", fifo_rst_ack_o, 1'b0);
        chk1("frst_ready_after", data_ready_o, 1'b0);

        // Character left unread trips the timeout after 640 sample edges
        send_frame(8'h42, 8, 1'b0, 1'b0);
        wait_edges(580);
        chk1("tmo_early", timeout_o, 1'b0);
        wait_edges(60);
        chk1("tmo_set", timeout_o, 1'b1);
        chk8("tmo_data", rbr_data_o, 8'h42);
        pulse_read();
        chk1("tmo_clr", timeout_o, 1'b0);
        chk1("tmo_ready_clr", data_ready_o, 1'b0);

        // Holding-register mode overwrites and flags overrun
        fifo_en_i = 1'b0;
        wait_edges(2);
        send_frame(8'h12, 8, 1'b0, 1'b0);
        send_frame(8'h34, 8, 1'b0, 1'b0);
        chk8("hold_data", rbr_data_o, 8'h34);
        chk1("hold_ready", data_ready_o, 1'b1);
        chk1("hold_overrun", overrun_o, 1'b1);
        chk1("hold_trigger", trigger_o, 1'b0);
        pulse_read();
        chk1("hold_ready_clr", data_ready_o, 1'b0);
        pulse_lsr();
        chk1("hold_overrun_clr", overrun_o, 1'b0);
        fifo_en_i = 1'b1;
        wait_edges(2);

        // Reset mid-frame with a character pending
        send_frame(8'h77, 8, 1'b0, 1'b0);
        rxd_i = 1'b0;
        wait_edges(40);
        rst_i = 1'b1;
        rxd_i = 1'b1;
        @(negedge clk_i);
        check_all_zero("midrst");
        rst_i = 1'b0;
        wait_edges(4);
        send_frame(8'h11, 8, 1'b0, 1'b0);
        chk8("post_rst_data", rbr_data_o, 8'h11);
        chk1("post_rst_ready", data_ready_o, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
